// File: rtl/matrix_unpack_tx.sv
// -----------------------------------------------------------------------------
// matrix_unpack_tx
//
// Purpose:
//   Takes a packed 2x2 matrix word {M00,M01,M10,M11} (M00 in the MSBs) and
//   emits its four elements one per output handshake, each tagged with its
//   (row, col) position.
//
//   Two word slots are kept:
//     - CUR:  the word being emitted, with a 2-bit element index.
//     - PEND: one word waiting behind CUR.
//   With PEND available, a continuously valid input stream is emitted
//   without bubbles across word boundaries.
//
// Configuration:
//   MATRIX_UNPACK_COLMAJOR_EN
//     - Undefined (default): row-major order M00, M01, M10, M11.
//     - Defined: column-major order M00, M10, M01, M11.
//
// Ports:
//   clk        in   1      rising-edge clock
//   rst        in   1      asynchronous active-high reset
//   in_valid   in   1      packed word offered
//   in_ready   out  1      block can take a word (no path from out_ready)
//   in_data    in   4*EW   packed matrix {M00,M01,M10,M11}
//   out_valid  out  1      element presented
//   out_ready  in   1      downstream accepts element
//   out_data   out  EW     current element (0 when out_valid=0)
//   out_row    out  1      row index of out_data
//   out_col    out  1      column index of out_data
//   out_last   out  1      fourth element of the word
//   word_cnt   out  16     number of fully emitted words, wrapping
// -----------------------------------------------------------------------------
module matrix_unpack_tx #(
    parameter int EW = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [4*EW-1:0] in_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [EW-1:0]   out_data,
    output logic            out_row,
    output logic            out_col,
    output logic            out_last,
    output logic [15:0]     word_cnt
);

    localparam int WW = 4 * EW;

    // -------------------------------------------------------------------------
    // Emission-order decode: element index -> matrix position.
    // -------------------------------------------------------------------------
    function automatic logic idx_row(input logic [1:0] idx);
`ifdef MATRIX_UNPACK_COLMAJOR_EN
        idx_row = idx[0];
`else
        idx_row = idx[1];
`endif
    endfunction

    function automatic logic idx_col(input logic [1:0] idx);
`ifdef MATRIX_UNPACK_COLMAJOR_EN
        idx_col = idx[1];
`else
        idx_col = idx[0];
`endif
    endfunction

    // Pick element M(row,col) out of the packed word (M00 in the MSBs).
    function automatic logic [EW-1:0] elem_sel(input logic [WW-1:0] w,
                                               input logic row,
                                               input logic col);
        logic [EW-1:0] e;
        case ({row, col})
            2'b00:   e = w[4*EW-1:3*EW];
            2'b01:   e = w[3*EW-1:2*EW];
            2'b10:   e = w[2*EW-1:EW];
            default: e = w[EW-1:0];
        endcase
        return e;
    endfunction

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic            cur_valid_q,  cur_valid_d;
    logic            pend_valid_q, pend_valid_d;
    logic [1:0]      idx_q,        idx_d;
    logic [15:0]     word_cnt_q,   word_cnt_d;
    logic [WW-1:0]   cur_data_q,   cur_data_d;
    logic [WW-1:0]   pend_data_q,  pend_data_d;
    // Holds in_ready low while reset is asserted and until the first clock
    // edge after release.
    logic            ready_en_q;

    logic            in_fire;
    logic            out_fire;
    logic            last_fire;
    logic            cur_row;
    logic            cur_col;

    // in_ready depends on registers only, so out_ready never reaches it
    // combinationally.
    assign in_ready  = ready_en_q & ~pend_valid_q;

    assign in_fire   = in_valid & in_ready;
    assign out_fire  = cur_valid_q & out_ready;
    assign last_fire = out_fire & (idx_q == 2'd3);

    // -------------------------------------------------------------------------
    // Next-state logic
    // -------------------------------------------------------------------------
    always_comb begin
        cur_valid_d  = cur_valid_q;
        pend_valid_d = pend_valid_q;
        idx_d        = idx_q;
        word_cnt_d   = word_cnt_q;
        cur_data_d   = cur_data_q;
        pend_data_d  = pend_data_q;

        if (last_fire) begin
            // CUR is freed this cycle: refill from PEND first so acceptance
            // order is preserved, else straight from the input.
            idx_d      = 2'd0;
            word_cnt_d = word_cnt_q + 16'd1;
            if (pend_valid_q) begin
                cur_data_d   = pend_data_q;
                pend_valid_d = 1'b0;
            end else if (in_fire) begin
                cur_data_d   = in_data;
            end else begin
                cur_valid_d  = 1'b0;
            end
        end else begin
            if (out_fire) begin
                idx_d = idx_q + 2'd1;
            end
            if (in_fire) begin
                // An empty CUR implies an empty PEND, so a new word can go
                // straight into CUR.
                if (!cur_valid_q) begin
                    cur_valid_d = 1'b1;
                    cur_data_d  = in_data;
                    idx_d       = 2'd0;
                end else begin
                    pend_valid_d = 1'b1;
                    pend_data_d  = in_data;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Control registers (reset)
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cur_valid_q  <= 1'b0;
            pend_valid_q <= 1'b0;
            idx_q        <= 2'd0;
            word_cnt_q   <= 16'd0;
            ready_en_q   <= 1'b0;
        end else begin
            cur_valid_q  <= cur_valid_d;
            pend_valid_q <= pend_valid_d;
            idx_q        <= idx_d;
            word_cnt_q   <= word_cnt_d;
            ready_en_q   <= 1'b1;
        end
    end

    // Word storage is qualified by the valid flags, so it needs no reset.
    always_ff @(posedge clk) begin
        cur_data_q  <= cur_data_d;
        pend_data_q <= pend_data_d;
    end

    // -------------------------------------------------------------------------
    // Output decode; everything is forced to 0 while CUR is empty.
    // -------------------------------------------------------------------------
    assign cur_row   = idx_row(idx_q);
    assign cur_col   = idx_col(idx_q);

    assign out_valid = cur_valid_q;
    assign out_row   = cur_valid_q & cur_row;
    assign out_col   = cur_valid_q & cur_col;
    assign out_last  = cur_valid_q & (idx_q == 2'd3);
    assign out_data  = cur_valid_q ? elem_sel(cur_data_q, cur_row, cur_col) : '0;
    assign word_cnt  = word_cnt_q;

endmodule

// File: doc/matrix_unpack_tx.md
MATRIX_UNPACK_TX -- requirements
Module: matrix_unpack_tx

Interface
REQ-001 Parameter: EW, default 8, element width in bits; the packed word is 4*EW bits.
REQ-002 Port: clk  input  1  sole clock, rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous, active-high.
REQ-004 Port: in_valid  input  1  packed 2x2 matrix word offered.
REQ-005 Port: in_ready  output  1  block can accept a word this cycle.
REQ-006 Port: in_data  input  4*EW  packed matrix {M00,M01,M10,M11}, with M00 in the MSBs.
REQ-007 Port: out_valid  output  1  element presented.
REQ-008 Port: out_ready  input  1  downstream accepts element.
REQ-009 Port: out_data  output  EW  current element.
REQ-010 Port: out_row  output  1  row index of out_data.
REQ-011 Port: out_col  output  1  column index of out_data.
REQ-012 Port: out_last  output  1  high on the fourth element of a word.
REQ-013 Port: word_cnt  output  16  count of fully emitted words, wrapping.

Function
REQ-014 A transfer occurs on either side only in a cycle where valid and ready are both high at the rising clk edge.
REQ-015 Storage is two word slots: CUR (being emitted) and PEND (waiting); in_ready = !PEND_valid, with no combinational path from out_ready.
REQ-016 An accepted word loads CUR if CUR is empty, or if CUR is freed that same cycle and PEND is empty; otherwise it loads PEND.
REQ-017 Latency: a word accepted at edge N makes out_valid high after edge N, with element 0 presented.
REQ-018 CUR holds a 2-bit element index; out_data, out_row and out_col are decoded from CUR and the index.
REQ-019 Default order is row-major: M00(0,0), M01(0,1), M10(1,0), M11(1,1).
REQ-020 While out_valid=1 and out_ready=0, out_data, out_row, out_col and out_last are held stable.
REQ-021 Each output handshake increments the index; out_last=1 exactly when the index is 3.
REQ-022 On the last handshake, CUR reloads from PEND if PEND is valid, else from a simultaneous input handshake, else CUR becomes empty; the index returns to 0.
REQ-023 The block sustains one element per cycle across word boundaries, with no bubble, whenever input is continuously valid.
REQ-024 word_cnt increments on each last handshake and wraps from 65535 to 0.
REQ-025 Words are emitted strictly in acceptance order; no word is dropped or duplicated.
REQ-026 When out_valid=0, out_data, out_row, out_col and out_last are 0.

Reset
REQ-027 rst asserted, asynchronously, clears CUR_valid, PEND_valid, the index and word_cnt, and forces out_valid=0, out_last=0, out_data=0, out_row=0 and out_col=0.
REQ-028 While rst is asserted, in_ready=0; after rst deasserts, in_ready=1 from the first clk edge.
REQ-029 Reset mid-word discards both slots with no partial emission afterwards.

Configuration
REQ-030 Macro MATRIX_UNPACK_COLMAJOR_EN, when defined, selects column-major order: M00(0,0), M10(1,0), M01(0,1), M11(1,1).
REQ-031 When MATRIX_UNPACK_COLMAJOR_EN is undefined, row-major order per REQ-019 applies; all other behaviour is identical in both cases.

Verification
REQ-032 Single word 0x01020304, out_ready held high -> out_data 01,02,03,04 on consecutive cycles with (row,col) = (0,0),(0,1),(1,0),(1,1); out_last only on 04; word_cnt=1.
REQ-033 Words 0xA0A1A2A3 and 0xB0B1B2B3 back-to-back, out_ready=1 -> 8 consecutive valid cycles A0..A3, B0..B3 with no gap.
REQ-034 out_ready low for 3 cycles on element 2 of 0x11223344 -> out_data=0x33 held stable, in_ready drops once PEND fills, and no data is lost.
REQ-035 rst pulsed after 2 elements of 0x55667788 with a second word in PEND -> out_valid=0 and word_cnt=0; next word 0x0A0B0C0D is emitted cleanly from element 0.
REQ-036 Build with MATRIX_UNPACK_COLMAJOR_EN, input 0x01020304 -> out_data 01,03,02,04 with (row,col) = (0,0),(1,0),(0,1),(1,1).
